decoder_seq: RTL
================

# decoder_seq

Parametrised, registered successor to the team's 3-to-8 one-hot decoder. It drives N = 2**SEL_W one-hot lines in one of three modes:
- direct registered decode;
- a free-running rotating scan with programmable dwell, for display or bank multiplexing;
- a one-shot strobe of programmable length with a busy handshake, for register-file and peripheral write strobes.

It sits between the control unit and the selectable resources, in place of bare combinational decoders where timing or strobing matters.

## Interface
Parameters:
- SEL_W, 3, select width; N_OUT = 2**SEL_W is derived, not overridable.
- DWELL_W, 8, width of the dwell/pulse-length operand.

Ports:
- CLK  in  1  single clock; everything updates on its rising edge.
- RST_N  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- EN  in  1  global enable; low forces idle.
- MODE  in  2  00 DECODE, 01 ROTATE, 10 PULSE, 11 reserved (idle).
- SEL  in  SEL_W  line index: decode target, rotate start index, or pulse target.
- DWELL  in  DWELL_W  hold/pulse length minus one.
- START  in  1  pulse request; PULSE mode only.
- OUT  out  N_OUT  one-hot or all-zero, registered.
- IDX  out  SEL_W  index of the currently or last driven line, registered.
- BUSY  out  1  high while a pulse is in progress.
- WRAP  out  1  one-cycle flag, ROTATE mode only: set when IDX advances from N_OUT-1 to 0.

## Operation
- Reset (RST_N low at an edge): OUT=0, IDX=0, BUSY=0, WRAP=0, cnt=0, dwell_q=0, state IDLE. Reset has priority over all other inputs.
- EN low at an edge: state IDLE, OUT=0, BUSY=0, WRAP=0, cnt=0; IDX holds.
- States: IDLE, DECODE, ROTATE, PULSE.
  - The next state is selected from MODE at every edge while EN=1; MODE=11 selects IDLE.
  - A mode change takes effect at the next edge and aborts any pulse in progress (BUSY drops).
- DECODE: every edge, OUT <= 1<<SEL and IDX <= SEL.
- ROTATE:
  - Entry edge, from any other state: IDX <= SEL, OUT <= 1<<SEL, cnt <= 0.
  - Later edges with cnt >= DWELL: IDX <= IDX+1 modulo N_OUT, cnt <= 0, and WRAP <= 1 if the old IDX was N_OUT-1.
  - Otherwise: cnt++ and WRAP <= 0.
  - DWELL is read live. Lowering DWELL below the current cnt advances IDX at the next edge; it never stalls the scan.
- PULSE:
  - With BUSY=0 and START=1 at an edge: IDX <= SEL, OUT <= 1<<SEL, dwell_q <= DWELL, cnt <= 0, BUSY <= 1.
  - While BUSY, at each edge: if cnt == dwell_q then OUT <= 0 and BUSY <= 0; else cnt++.
  - START is ignored while BUSY=1, including on the final pulse cycle.
- OUT never has more than one bit set. It is all-zero in IDLE and outside pulses.

## Timing
- Every output is registered, so each input sampled at edge k shows on the outputs after edge k. Latency is 1 cycle in all modes.
- DECODE: a SEL change is visible on OUT exactly one cycle later.
- ROTATE: each index is held for DWELL+1 cycles. DWELL=0 gives a new line every cycle. A full scan takes N_OUT*(DWELL+1) cycles.
- PULSE: OUT is high for exactly dwell_q+1 cycles. BUSY matches OUT cycle-for-cycle.
  - The earliest restart is a START sampled at the edge where BUSY falls; that START is ignored.
  - The first START that is accepted is the one sampled at the following edge.
  - This leaves one minimum idle cycle between pulses.
- WRAP is high for exactly the one cycle in which IDX is 0 after a wrap. It is never set on ROTATE entry, even when SEL=0.

## Structure
- Package decoder_pkg holds:
  - the mode constants MODE_DECODE, MODE_ROTATE, MODE_PULSE, MODE_RSVD;
  - the state enum, typedef dec_state_t, with values IDLE, DECODE, ROTATE, PULSE.
- Sub-module onehot_dec (combinational, parameter SEL_W): input index plus enable, output N_OUT one-hot or zero. Instantiate it once to produce the next-state OUT from the selected index.
- The top level holds the state register, cnt/dwell_q (DWELL_W bits), IDX, BUSY and WRAP.

## Test plan
- Reset: hold RST_N=0 for 2 edges with random inputs, then release with EN=0 -> OUT=0, IDX=0, BUSY=0, WRAP=0 throughout.
- DECODE, SEL_W=3: sweep SEL 0..7 one per cycle -> OUT = 0x01..0x80, each one cycle after its SEL. Drop EN -> OUT=0 the next cycle.
- ROTATE, SEL=6, DWELL=2 -> IDX sequence 6,6,6,7,7,7,0,0,0,1... WRAP high only on the first cycle of IDX=0. Change DWELL to 0 mid-hold with cnt=2 -> IDX advances at the next edge.
- PULSE, SEL=5, DWELL=3, START for 1 cycle -> OUT=0x20 and BUSY=1 for 4 cycles, then 0. START held continuously -> pulses of 4 cycles separated by exactly 1 idle cycle.
- Abort: start a pulse with DWELL=10, switch MODE to DECODE after 3 cycles -> BUSY drops and OUT=1<<SEL next cycle. Assert RST_N=0 mid-ROTATE -> all outputs reset at that edge.
- SEL_W=4, DWELL_W=4: ROTATE with DWELL=15 -> a full scan of 16 lines takes 256 cycles, with one WRAP pulse per scan.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared definitions for decoder_seq: the MODE encodings and the
//   controller state enum, plus a helper that maps a MODE value to the
//   state it selects.
package decoder_pkg;

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ROTATE = 2'd2,
    PULSE  = 2'd3
  } dec_state_t;

  // The reserved encoding parks the block in IDLE.
  function automatic dec_state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_DECODE: return DECODE;
      MODE_ROTATE: return ROTATE;
      MODE_PULSE:  return PULSE;
      default:     return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/decoder_seq_onehot_dec.sv
// onehot_dec
//   Combinational index-to-one-hot decoder with enable.
//   Ports:
//     i_idx     in  SEL_W  line index
//     i_en      in  1      enable; low gives all-zero output
//     o_onehot  out N_OUT  one-hot (i_en=1) or zero (i_en=0)
module onehot_dec #(
  parameter  int SEL_W = 3,
  localparam int N_OUT = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N_OUT-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq
//   Registered one-hot line driver with three modes: direct decode,
//   rotating scan with programmable dwell, and one-shot strobe with busy.
//   Ports:
//     CLK    in  1        clock, rising edge
//     RST_N  in  1        synchronous active-low reset
//     EN     in  1        global enable; low forces idle
//     MODE   in  2        00 decode, 01 rotate, 10 pulse, 11 idle
//     SEL    in  SEL_W    decode target / rotate start / pulse target
//     DWELL  in  DWELL_W  hold or pulse length minus one
//     START  in  1        pulse request (pulse mode)
//     OUT    out N_OUT    one-hot or zero, registered
//     IDX    out SEL_W    index of current/last driven line, registered
//     BUSY   out 1        pulse in progress
//     WRAP   out 1        one-cycle flag when rotate index wraps to 0
module decoder_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int N_OUT   = 2 ** SEL_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [1:0]         MODE,
  input  logic [SEL_W-1:0]   SEL,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               START,
  output logic [N_OUT-1:0]   OUT,
  output logic [SEL_W-1:0]   IDX,
  output logic               BUSY,
  output logic               WRAP
);

  dec_state_t         r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell_q;
  logic [SEL_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_wrap;
  logic [N_OUT-1:0]   r_out;

  logic               w_rot_entry;
  logic               w_rot_adv;
  logic               w_pulse_end;
  logic [SEL_W-1:0]   w_idx_inc;
  logic [SEL_W-1:0]   w_oh_idx;
  logic               w_oh_en;
  logic [N_OUT-1:0]   w_onehot;

  // Selects which line (if any) OUT drives after the coming edge; the
  // branch structure mirrors the state update below.
  always_comb begin
    w_rot_entry = (r_state != ROTATE);
    // DWELL is compared live, so lowering it below cnt advances at once.
    w_rot_adv   = (r_cnt >= DWELL);
    w_pulse_end = r_busy && (r_cnt == r_dwell_q);
    w_idx_inc   = r_idx + 1'b1;
    w_oh_idx    = r_idx;
    w_oh_en     = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_DECODE: begin
          w_oh_idx = SEL;
          w_oh_en  = 1'b1;
        end
        MODE_ROTATE: begin
          w_oh_en = 1'b1;
          if (w_rot_entry)    w_oh_idx = SEL;
          else if (w_rot_adv) w_oh_idx = w_idx_inc;
        end
        MODE_PULSE: begin
          if (r_busy) begin
            w_oh_en = !w_pulse_end;
          end else if (START) begin
            w_oh_idx = SEL;
            w_oh_en  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  onehot_dec #(.SEL_W(SEL_W)) u_onehot (
    .i_idx    (w_oh_idx),
    .i_en     (w_oh_en),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dwell_q <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_wrap    <= 1'b0;
      r_out     <= '0;
    end else begin
      r_out  <= w_onehot;
      r_wrap <= 1'b0;
      if (!EN) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_state <= mode_to_state(MODE);
        case (MODE)
          MODE_DECODE: begin
            r_idx  <= SEL;
            r_busy <= 1'b0;
            r_cnt  <= '0;
          end
          MODE_ROTATE: begin
            r_busy <= 1'b0;
            if (w_rot_entry) begin
              r_idx <= SEL;
              r_cnt <= '0;
            end else if (w_rot_adv) begin
              r_idx  <= w_idx_inc;
              r_cnt  <= '0;
              r_wrap <= (r_idx == '1);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          MODE_PULSE: begin
            // START is only looked at while idle, so a request on the
            // final pulse cycle is dropped.
            if (r_busy) begin
              if (w_pulse_end) r_busy <= 1'b0;
              else             r_cnt  <= r_cnt + 1'b1;
            end else if (START) begin
              r_idx     <= SEL;
              r_dwell_q <= DWELL;
              r_cnt     <= '0;
              r_busy    <= 1'b1;
            end else begin
              r_cnt <= '0;
            end
          end
          default: begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
          end
        endcase
      end
    end
  end

  assign OUT  = r_out;
  assign IDX  = r_idx;
  assign BUSY = r_busy;
  assign WRAP = r_wrap;

endmodule
